dsp_mac_pipe: RTL

//  Pipelined 18x18 signed pre-add/multiply/accumulate datapath for the Spartan-6 DSP48A1 model.

---
 rtl/dsp_mac_pipe_if.sv | 25 ++
 rtl/dsp_mac_pipe.sv | 137 +++++++++++++
 2 files changed

// File: rtl/dsp_mac_pipe_if.sv
// Operand/control beat into the MAC pipe and the P result coming back out.
// No ready signal: the pipe accepts one beat every cycle.
interface dsp_mac_pipe_if;
  logic               in_valid;
  logic signed [17:0] a;
  logic signed [17:0] b;
  logic signed [17:0] d;
  logic               use_preadd;
  logic               pre_sub;
  logic               acc_en;
  logic               acc_clr;
  logic               out_valid;
  logic signed [47:0] p;
  logic               carryout;

  modport master (
    output in_valid, a, b, d, use_preadd, pre_sub, acc_en, acc_clr,
    input  out_valid, p, carryout
  );

  modport slave (
    input  in_valid, a, b, d, use_preadd, pre_sub, acc_en, acc_clr,
    output out_valid, p, carryout
  );
endinterface

// File: rtl/dsp_mac_pipe.sv
// 18x18 signed pre-add/multiply/accumulate pipe; latency IREG+MREG+PREG cycles.
// No backpressure: a beat is accepted every cycle that in_valid is high.
module dsp_mac_pipe #(
  parameter int IREG = 1,
  parameter int MREG = 1,
  parameter int PREG = 1
) (
  input  logic           clk,
  input  logic           rst_n,
  dsp_mac_pipe_if.slave  bus
);

  typedef struct packed {
    logic [17:0] a;
    logic [17:0] b;
    logic [17:0] d;
    logic        use_preadd;
    logic        pre_sub;
    logic        acc_en;
    logic        acc_clr;
  } beat_t;

  beat_t              in_beat;
  beat_t              s1_beat;
  logic               s1_vld;
  logic [17:0]        pre_sum;
  logic [17:0]        b_sel;
  logic signed [35:0] a_ext;
  logic signed [35:0] b_ext;
  logic signed [35:0] m_prod;
  logic signed [35:0] m_q;
  logic               m_vld;
  logic               m_acc_en;
  logic               m_acc_clr;
  logic [47:0]        m_ext;

  always_comb begin
    in_beat            = '0;
    in_beat.a          = bus.a;
    in_beat.b          = bus.b;
    in_beat.d          = bus.d;
    in_beat.use_preadd = bus.use_preadd;
    in_beat.pre_sub    = bus.pre_sub;
    in_beat.acc_en     = bus.acc_en;
    in_beat.acc_clr    = bus.acc_clr;
  end

  generate
    if (IREG != 0) begin : g_ireg
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          s1_vld  <= 1'b0;
          s1_beat <= '0;
        end else begin
          s1_vld  <= bus.in_valid;
          s1_beat <= in_beat;
        end
      end
    end else begin : g_ireg_byp
      assign s1_vld  = bus.in_valid;
      assign s1_beat = in_beat;
    end
  endgenerate

  // Pre-adder wraps at 18 bits; operands are sign-extended so the product is exact.
  always_comb begin
    pre_sum = s1_beat.pre_sub ? (s1_beat.d - s1_beat.b) : (s1_beat.d + s1_beat.b);
    b_sel   = s1_beat.use_preadd ? pre_sum : s1_beat.b;
    a_ext   = {{18{s1_beat.a[17]}}, s1_beat.a};
    b_ext   = {{18{b_sel[17]}}, b_sel};
    m_prod  = a_ext * b_ext;
  end

  generate
    if (MREG != 0) begin : g_mreg
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          m_vld     <= 1'b0;
          m_q       <= '0;
          m_acc_en  <= 1'b0;
          m_acc_clr <= 1'b0;
        end else begin
          m_vld     <= s1_vld;
          m_q       <= m_prod;
          m_acc_en  <= s1_beat.acc_en;
          m_acc_clr <= s1_beat.acc_clr;
        end
      end
    end else begin : g_mreg_byp
      assign m_vld     = s1_vld;
      assign m_q       = m_prod;
      assign m_acc_en  = s1_beat.acc_en;
      assign m_acc_clr = s1_beat.acc_clr;
    end
  endgenerate

  assign m_ext = {{12{m_q[35]}}, m_q};

  generate
    if (PREG != 0) begin : g_preg
      logic [47:0] p_q;
      logic        carry_q;
      logic        out_vld_q;
      logic [48:0] acc_sum;

      assign acc_sum = {1'b0, p_q} + {1'b0, m_ext};

      // P and carry only move on a valid beat, so bubbles leave the accumulator intact.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          p_q       <= '0;
          carry_q   <= 1'b0;
          out_vld_q <= 1'b0;
        end else begin
          out_vld_q <= m_vld;
          if (m_vld) begin
            if (m_acc_en && !m_acc_clr) begin
              {carry_q, p_q} <= acc_sum;
            end else begin
              p_q     <= m_ext;
              carry_q <= 1'b0;
            end
          end
        end
      end

      assign bus.p         = p_q;
      assign bus.carryout  = carry_q;
      assign bus.out_valid = out_vld_q;
    end else begin : g_preg_byp
      assign bus.p         = m_ext;
      assign bus.carryout  = 1'b0;
      assign bus.out_valid = m_vld;
    end
  endgenerate

endmodule
